gemm_tile_engine: RTL and testbench



---
 rtl/gemm_tile_pkg.sv | 17 +
 rtl/gemm_acc_pe.sv | 25 ++
 rtl/gemm_tile_engine.sv | 170 +++++++++++++++++
 tb/tb_gemm_tile_engine.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gemm_tile_pkg.sv
// Shared types and helpers for the tiled GeMM engine.
package gemm_tile_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, DRAIN, DONE} state_e;

  // Width used for address and remainder arithmetic before truncation.
  localparam int CALC_W = 32;

  function automatic int unsigned ceil_div(input int unsigned x, input int unsigned d);
    return (x + d - 1) / d;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/gemm_acc_pe.sv
// One signed multiply-accumulate cell; the product is sign-extended and the sum wraps.
module gemm_acc_pe #(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           en,
  input  logic signed [InDataWidth-1:0]  a,
  input  logic signed [InDataWidth-1:0]  b,
  output logic signed [OutDataWidth-1:0] acc
);

  logic signed [2*InDataWidth-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + OutDataWidth'(prod);
  end

endmodule

// File: rtl/gemm_tile_engine.sv
// Output-stationary tiled GeMM: streams K A/B words per tile, then drains one C row per cycle.
module gemm_tile_engine
  import gemm_tile_pkg::*;
#(
  parameter int InDataWidth   = 8,
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 16,
  parameter int SizeAddrWidth = 8,
  parameter int RowPar        = 4,
  parameter int ColPar        = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [SizeAddrWidth-1:0]        M_size_i,
  input  logic [SizeAddrWidth-1:0]        K_size_i,
  input  logic [SizeAddrWidth-1:0]        N_size_i,
  output logic [AddrWidth-1:0]            sram_a_addr_o,
  output logic [AddrWidth-1:0]            sram_b_addr_o,
  output logic                            sram_ab_re_o,
  input  logic [RowPar*InDataWidth-1:0]   sram_a_rdata_i,
  input  logic [ColPar*InDataWidth-1:0]   sram_b_rdata_i,
  output logic [AddrWidth-1:0]            sram_c_addr_o,
  output logic [ColPar*OutDataWidth-1:0]  sram_c_wdata_o,
  output logic [ColPar-1:0]               sram_c_wmask_o,
  output logic                            sram_c_we_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int SW = SizeAddrWidth;
  localparam int RW = (RowPar > 1) ? $clog2(RowPar) : 1;
  localparam logic [SW-1:0] ONE = SW'(1);

  state_e state;
  logic [SW-1:0] m_sz, k_sz, n_sz, mt_cnt, nt_cnt, m_tile, n_tile, k, rows_v, cols_v;
  logic [RW-1:0] r;
  logic          vld_pipe;

  logic [SW-1:0]     sz_m, sz_k, sz_n, setup_m, setup_n;
  logic              n_wrap, last_tile, r_last, zero_sz, tile_go, clr;
  logic [CALC_W-1:0] m_rem, n_rem, a_base, b_base, c_first;
  logic [ColPar-1:0] mask_nx;

  logic [RowPar-1:0][InDataWidth-1:0]              a_lane;
  logic [ColPar-1:0][InDataWidth-1:0]              b_lane;
  logic [RowPar-1:0][ColPar-1:0][OutDataWidth-1:0] acc;

  // setup_* is the tile about to be loaded: (0,0) from IDLE, else the successor of the current one.
  always_comb begin
    sz_m      = (state == IDLE) ? M_size_i : m_sz;
    sz_k      = (state == IDLE) ? K_size_i : k_sz;
    sz_n      = (state == IDLE) ? N_size_i : n_sz;
    zero_sz   = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
    n_wrap    = (n_tile == nt_cnt - ONE);
    last_tile = n_wrap && (m_tile == mt_cnt - ONE);
    r_last    = (SW'(r) == rows_v - ONE);
    setup_m   = '0;
    setup_n   = '0;
    if (state != IDLE) begin
      setup_m = n_wrap ? m_tile + ONE : m_tile;
      setup_n = n_wrap ? '0 : n_tile + ONE;
    end
    m_rem   = CALC_W'(sz_m) - CALC_W'(setup_m) * CALC_W'(RowPar);
    n_rem   = CALC_W'(sz_n) - CALC_W'(setup_n) * CALC_W'(ColPar);
    a_base  = CALC_W'(setup_m) * CALC_W'(sz_k);
    b_base  = CALC_W'(setup_n) * CALC_W'(sz_k);
    c_first = CALC_W'(m_tile) * CALC_W'(RowPar) * CALC_W'(nt_cnt) + CALC_W'(n_tile);
    tile_go = ((state == IDLE) && start_i && !zero_sz) ||
              ((state == DRAIN) && r_last && !last_tile);
    for (int j = 0; j < ColPar; j++) mask_nx[j] = (CALC_W'(j) < CALC_W'(cols_v));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      m_sz <= '0; k_sz <= '0; n_sz <= '0; mt_cnt <= '0; nt_cnt <= '0;
      m_tile <= '0; n_tile <= '0; k <= '0; r <= '0; rows_v <= '0; cols_v <= '0;
      vld_pipe <= 1'b0;
      sram_a_addr_o <= '0; sram_b_addr_o <= '0; sram_ab_re_o <= 1'b0;
      sram_c_addr_o <= '0; sram_c_wmask_o <= '0; sram_c_we_o <= 1'b0;
      busy_o <= 1'b0; done_o <= 1'b0;
    end else begin
      vld_pipe <= sram_ab_re_o;
      done_o   <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          m_sz   <= M_size_i;
          k_sz   <= K_size_i;
          n_sz   <= N_size_i;
          mt_cnt <= SW'(ceil_div(CALC_W'(M_size_i), RowPar));
          nt_cnt <= SW'(ceil_div(CALC_W'(N_size_i), ColPar));
          busy_o <= !zero_sz;
          if (zero_sz) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        LOAD: if (k == k_sz - ONE) begin
          state        <= WAIT;
          sram_ab_re_o <= 1'b0;
        end else begin
          k             <= k + ONE;
          sram_a_addr_o <= sram_a_addr_o + AddrWidth'(1);
          sram_b_addr_o <= sram_b_addr_o + AddrWidth'(1);
        end
        WAIT: begin
          state          <= DRAIN;
          r              <= '0;
          sram_c_we_o    <= 1'b1;
          sram_c_addr_o  <= AddrWidth'(c_first);
          sram_c_wmask_o <= mask_nx;
        end
        DRAIN: if (r_last) begin
          sram_c_we_o    <= 1'b0;
          sram_c_wmask_o <= '0;
          if (last_tile) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end else begin
          r             <= r + RW'(1);
          sram_c_addr_o <= sram_c_addr_o + AddrWidth'(nt_cnt);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (tile_go) begin
        state         <= LOAD;
        m_tile        <= setup_m;
        n_tile        <= setup_n;
        k             <= '0;
        rows_v        <= (m_rem < CALC_W'(RowPar)) ? SW'(m_rem) : SW'(RowPar);
        cols_v        <= (n_rem < CALC_W'(ColPar)) ? SW'(n_rem) : SW'(ColPar);
        sram_ab_re_o  <= 1'b1;
        sram_a_addr_o <= AddrWidth'(a_base);
        sram_b_addr_o <= AddrWidth'(b_base);
      end
    end
  end

  // Clear lands while the first word of the tile is still in flight, so no data is lost.
  assign clr = (state == LOAD) && (k == '0);

  assign sram_c_wdata_o = sram_c_we_o ? acc[r] : '0;

  for (genvar gi = 0; gi < RowPar; gi++) begin : g_a
    assign a_lane[gi] = (SW'(gi) < rows_v) ? sram_a_rdata_i[lane_lsb(gi, InDataWidth) +: InDataWidth] : '0;
  end

  for (genvar gj = 0; gj < ColPar; gj++) begin : g_b
    assign b_lane[gj] = (SW'(gj) < cols_v) ? sram_b_rdata_i[lane_lsb(gj, InDataWidth) +: InDataWidth] : '0;
  end

  for (genvar gi = 0; gi < RowPar; gi++) begin : g_row
    for (genvar gj = 0; gj < ColPar; gj++) begin : g_col
      gemm_acc_pe #(.InDataWidth(InDataWidth), .OutDataWidth(OutDataWidth)) u_pe (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (clr),
        .en    (vld_pipe),
        .a     (a_lane[gi]),
        .b     (b_lane[gj]),
        .acc   (acc[gi][gj])
      );
    end
  end

endmodule

// File: tb/tb_gemm_tile_engine.sv
// Directed bench: SRAM model with 1-cycle read latency, element-level golden C and address scoreboards.
module tb_gemm_tile_engine;

  localparam int IW = 8, OW = 32, AW = 16, SW = 8, RP = 4, CP = 16, CW = CP * OW;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [SW-1:0] m_size = '0, k_size = '0, n_size = '0;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic re, we, busy, done;
  logic [RP*IW-1:0] a_rdata = '0;
  logic [CP*IW-1:0] b_rdata = '0;
  logic [CW-1:0]    c_wdata;
  logic [CP-1:0]    c_wmask;

  typedef struct { logic [AW-1:0] a; logic [AW-1:0] b; } rd_t;
  typedef struct { logic [AW-1:0] addr; logic [CW-1:0] data; logic [CP-1:0] mask; } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  checks = 0, errors = 0, done_cnt = 0;
  int  a_el [0:15][0:7];
  int  b_el [0:7][0:47];
  logic [RP*IW-1:0] a_mem [0:255];
  logic [CP*IW-1:0] b_mem [0:255];

  gemm_tile_engine #(
    .InDataWidth(IW), .OutDataWidth(OW), .AddrWidth(AW),
    .SizeAddrWidth(SW), .RowPar(RP), .ColPar(CP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
    .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr), .sram_ab_re_o(re),
    .sram_a_rdata_i(a_rdata), .sram_b_rdata_i(b_rdata),
    .sram_c_addr_o(c_addr), .sram_c_wdata_o(c_wdata), .sram_c_wmask_o(c_wmask),
    .sram_c_we_o(we), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (re) begin
    a_rdata <= a_mem[a_addr[7:0]];
    b_rdata <= b_mem[b_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (re) begin
      chk("rd_expected", CW'(rd_q.size() > 0), CW'(1));
      if (rd_q.size() > 0) begin
        rd_t e;
        e = rd_q.pop_front();
        chk("a_addr", CW'(a_addr), CW'(e.a));
        chk("b_addr", CW'(b_addr), CW'(e.b));
      end
    end
    if (we) begin
      chk("wr_expected", CW'(wr_q.size() > 0), CW'(1));
      if (wr_q.size() > 0) begin
        wr_t w;
        w = wr_q.pop_front();
        chk("c_addr", CW'(c_addr), CW'(w.addr));
        chk("c_wmask", CW'(c_wmask), CW'(w.mask));
        chk("c_wdata", c_wdata, w.data);
      end
    end
    if (done) done_cnt++;
  end

  // Builds element matrices, packs them into SRAM (garbage in out-of-range lanes), queues expectations.
  task automatic prep(input int m, input int k, input int n, input int av, input int bv, input int rnd);
    int mt, nt, rows, cols, s;
    wr_t w;
    rd_t e;
    mt = (m + RP - 1) / RP;
    nt = (n + CP - 1) / CP;
    for (int i = 0; i < 16; i++)
      for (int kk = 0; kk < 8; kk++) a_el[i][kk] = (rnd != 0) ? int'($urandom_range(255)) - 128 : av;
    for (int kk = 0; kk < 8; kk++)
      for (int j = 0; j < 48; j++) b_el[kk][j] = (rnd != 0) ? int'($urandom_range(255)) - 128 : bv;
    for (int x = 0; x < 256; x++) begin
      a_mem[x] = $urandom();
      b_mem[x] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    for (int tm = 0; tm < mt; tm++)
      for (int kk = 0; kk < k; kk++)
        for (int i = 0; i < RP; i++)
          if (tm * RP + i < m) a_mem[tm*k+kk][i*IW +: IW] = IW'(a_el[tm*RP+i][kk]);
    for (int tn = 0; tn < nt; tn++)
      for (int kk = 0; kk < k; kk++)
        for (int j = 0; j < CP; j++)
          if (tn * CP + j < n) b_mem[tn*k+kk][j*IW +: IW] = IW'(b_el[kk][tn*CP+j]);
    if (m > 0 && k > 0 && n > 0)
      for (int tm = 0; tm < mt; tm++)
        for (int tn = 0; tn < nt; tn++) begin
          for (int kk = 0; kk < k; kk++) begin
            e.a = AW'(tm * k + kk);
            e.b = AW'(tn * k + kk);
            rd_q.push_back(e);
          end
          rows = (m - tm * RP < RP) ? m - tm * RP : RP;
          cols = (n - tn * CP < CP) ? n - tn * CP : CP;
          for (int r = 0; r < rows; r++) begin
            w.addr = AW'((tm * RP + r) * nt + tn);
            w.data = '0;
            w.mask = '0;
            for (int j = 0; j < cols; j++) begin
              s = 0;
              for (int kk = 0; kk < k; kk++) s += a_el[tm*RP+r][kk] * b_el[kk][tn*CP+j];
              w.data[j*OW +: OW] = OW'(s);
              w.mask[j] = 1'b1;
            end
            wr_q.push_back(w);
          end
        end
  endtask

  // Start is driven in cycle 0; done must appear exactly in cycle exp_cyc.
  task automatic run_op(input string tag, input int m, input int k, input int n,
                        input int av, input int bv, input int rnd, input int glitch, input int exp_cyc);
    int cyc, d0;
    prep(m, k, n, av, bv, rnd);
    d0 = done_cnt;
    @(posedge clk); #1;
    m_size = SW'(m); k_size = SW'(k); n_size = SW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    if (m > 0 && k > 0 && n > 0) chk({tag, "_busy"}, CW'(busy), CW'(1));
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = (glitch != 0 && cyc == 2);
      if (glitch != 0 && cyc == 2) begin m_size = 1; k_size = 1; n_size = 1; end
    end
    start = 1'b0;
    chk({tag, "_done_cyc"}, CW'(cyc), CW'(exp_cyc));
    chk({tag, "_busy_done"}, CW'(busy), CW'(0));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, CW'(done_cnt - d0), CW'(1));
    chk({tag, "_wr_left"}, CW'(wr_q.size()), CW'(0));
    chk({tag, "_rd_left"}, CW'(rd_q.size()), CW'(0));
  endtask

  initial begin
    int cyc, d0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ctl", CW'({re, we, busy, done, a_addr, b_addr, c_addr, c_wmask}), '0);
    chk("reset_wdata", c_wdata, '0);
    #10 rst_n = 1'b1;

    run_op("full",    4, 2, 16,    1,    2, 0, 0,  8);
    run_op("partial", 3, 3,  5,    0,    0, 1, 0,  8);
    run_op("multi",   8, 3, 32,    0,    0, 1, 0, 33);
    run_op("ragged",  5, 2, 20,    0,    0, 1, 0, 23);
    run_op("signed",  4, 4, 16, -128, -128, 0, 0, 10);
    run_op("zero_k",  4, 0, 16,    0,    0, 1, 0,  1);
    run_op("busy_st", 4, 3, 16,    0,    0, 1, 1,  9);

    // Reset in the middle of DRAIN, then confirm the engine is quiet and reusable.
    prep(4, 2, 16, 0, 0, 1);
    d0 = done_cnt;
    @(posedge clk); #1;
    m_size = 4; k_size = 2; n_size = 16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!we && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_reach_drain", CW'(we), CW'(1));
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", CW'({re, we, busy, done, a_addr, b_addr, c_addr, c_wmask}), '0);
    chk("rst_mid_wdata", c_wdata, '0);
    rd_q.delete();
    wr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_done", CW'(done_cnt - d0), CW'(0));
    chk("rst_idle", CW'({busy, re, we}), CW'(0));
    run_op("post_rst", 4, 1, 16, 0, 0, 1, 0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
